// File: rtl/mem_wb_stage.sv
// MEM->WB pipeline register with a valid/ready handshake, 2-entry skid buffer,
// synchronous flush and a write-back data mux evaluated before the flop.
// Optional WB forwarding comparators are enabled by defining WB_FWD_EN.
module mem_wb_stage #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int RD_W    = 5,
  parameter int NUM_SRC = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [ADDR_W-1:0]        in_alu_result,
  input  logic [DATA_W-1:0]        in_read_data,
  input  logic [RD_W-1:0]          in_rd,
  input  logic                     in_mem_to_reg,
  input  logic                     in_reg_write,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [ADDR_W-1:0]        out_alu_result,
  output logic [DATA_W-1:0]        out_read_data,
  output logic [RD_W-1:0]          out_rd,
  output logic                     out_mem_to_reg,
  output logic                     out_reg_write,
`ifdef WB_FWD_EN
  input  logic [NUM_SRC*RD_W-1:0]   fwd_rs,
  output logic [NUM_SRC-1:0]        fwd_hit,
  output logic [NUM_SRC*DATA_W-1:0] fwd_data,
`endif
  output logic [DATA_W-1:0]        out_wb_data
);

  typedef struct packed {
    logic              reg_write;
    logic              mem_to_reg;
    logic [RD_W-1:0]   rd;
    logic [ADDR_W-1:0] alu_result;
    logic [DATA_W-1:0] read_data;
    logic [DATA_W-1:0] wb_data;
  } entry_t;

  localparam int ENT_W = $bits(entry_t);

  entry_t main_r;
  entry_t skid_r;
  entry_t cap_s;
  logic   main_valid_r;
  logic   skid_valid_r;
  logic   in_ready_r;
  logic   accept_s;
  logic   emit_s;

  assign accept_s = in_valid & in_ready_r;
  assign emit_s   = main_valid_r & out_ready;

  // Capture entry: rd==0 never writes, wb data is selected before the flop.
  always_comb begin
    cap_s            = entry_t'({ENT_W{1'b0}});
    cap_s.reg_write  = in_reg_write & (in_rd != {RD_W{1'b0}});
    cap_s.mem_to_reg = in_mem_to_reg;
    cap_s.rd         = in_rd;
    cap_s.alu_result = in_alu_result;
    cap_s.read_data  = in_read_data;
    if (in_mem_to_reg) begin
      cap_s.wb_data = in_read_data;
    end else begin
      cap_s.wb_data = DATA_W'(in_alu_result);
    end
  end

  // Main/skid storage; reg_write is cleared whenever the main entry goes invalid.
  always_ff @(posedge clk) begin
    if (rst) begin
      main_r       <= entry_t'({ENT_W{1'b0}});
      skid_r       <= entry_t'({ENT_W{1'b0}});
      main_valid_r <= 1'b0;
      skid_valid_r <= 1'b0;
      in_ready_r   <= 1'b1;
    end else if (flush) begin
      main_valid_r     <= 1'b0;
      skid_valid_r     <= 1'b0;
      main_r.reg_write <= 1'b0;
      skid_r.reg_write <= 1'b0;
      in_ready_r       <= 1'b1;
    end else if (emit_s && skid_valid_r) begin
      main_r       <= skid_r;
      skid_valid_r <= 1'b0;
      in_ready_r   <= 1'b1;
    end else if (emit_s && accept_s) begin
      main_r <= cap_s;
    end else if (emit_s) begin
      main_valid_r     <= 1'b0;
      main_r.reg_write <= 1'b0;
    end else if (accept_s && main_valid_r) begin
      skid_r       <= cap_s;
      skid_valid_r <= 1'b1;
      in_ready_r   <= 1'b0;
    end else if (accept_s) begin
      main_r       <= cap_s;
      main_valid_r <= 1'b1;
    end else begin
      main_valid_r <= main_valid_r;
    end
  end

  assign in_ready       = in_ready_r;
  assign out_valid      = main_valid_r;
  assign out_alu_result = main_r.alu_result;
  assign out_read_data  = main_r.read_data;
  assign out_rd         = main_r.rd;
  assign out_mem_to_reg = main_r.mem_to_reg;
  assign out_reg_write  = main_r.reg_write;
  assign out_wb_data    = main_r.wb_data;

`ifdef WB_FWD_EN
  // Forward the main entry only; a source index of 0 never hits.
  always_comb begin
    fwd_hit  = {NUM_SRC{1'b0}};
    fwd_data = {(NUM_SRC*DATA_W){1'b0}};
    for (int i = 0; i < NUM_SRC; i++) begin
      if (main_valid_r && main_r.reg_write &&
          (main_r.rd == fwd_rs[i*RD_W +: RD_W]) &&
          (fwd_rs[i*RD_W +: RD_W] != {RD_W{1'b0}})) begin
        fwd_hit[i]                  = 1'b1;
        fwd_data[i*DATA_W +: DATA_W] = main_r.wb_data;
      end else begin
        fwd_hit[i] = 1'b0;
      end
    end
  end
`endif

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed self-checking bench for mem_wb_stage; forwarding checks run only
// when WB_FWD_EN is defined.
module tb_mem_wb_stage;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, in_ready;
  logic [31:0] in_alu_result, in_read_data;
  logic [4:0]  in_rd;
  logic        in_mem_to_reg, in_reg_write;
  logic        out_valid, out_ready;
  logic [31:0] out_alu_result, out_read_data, out_wb_data;
  logic [4:0]  out_rd;
  logic        out_mem_to_reg, out_reg_write;
`ifdef WB_FWD_EN
  logic [9:0]  fwd_rs;
  logic [1:0]  fwd_hit;
  logic [63:0] fwd_data;
`endif

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  mem_wb_stage dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_alu_result(in_alu_result), .in_read_data(in_read_data), .in_rd(in_rd),
    .in_mem_to_reg(in_mem_to_reg), .in_reg_write(in_reg_write),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_alu_result(out_alu_result), .out_read_data(out_read_data), .out_rd(out_rd),
    .out_mem_to_reg(out_mem_to_reg), .out_reg_write(out_reg_write),
`ifdef WB_FWD_EN
    .fwd_rs(fwd_rs), .fwd_hit(fwd_hit), .fwd_data(fwd_data),
`endif
    .out_wb_data(out_wb_data)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] alu, input logic [31:0] rdata,
                       input logic [4:0] rd, input logic m2r, input logic rw);
    in_valid = v; in_alu_result = alu; in_read_data = rdata;
    in_rd = rd; in_mem_to_reg = m2r; in_reg_write = rw;
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
    drive(1'b1, 32'h1111_1111, 32'h2222_2222, 5'd6, 1'b1, 1'b1);
    tick(); tick();
    rst = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0);
    vectors++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_hs: out_valid=%b in_ready=%b, want 0/1", out_valid, in_ready);
    end
    vectors++;
    if ({out_alu_result, out_read_data, out_wb_data, out_rd, out_mem_to_reg, out_reg_write} !== 103'd0) begin
      miscompares++;
      $display("FAIL reset_data: alu=%h rdata=%h wb=%h rd=%0d m2r=%b rw=%b, want all 0",
               out_alu_result, out_read_data, out_wb_data, out_rd, out_mem_to_reg, out_reg_write);
    end
  endtask

  task automatic test_basic();
    out_ready = 1'b1;
    drive(1'b1, 32'h0000_0010, 32'h1234_5678, 5'd3, 1'b0, 1'b1);
    tick();
    drive(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0);
    vectors++;
    if (out_valid !== 1'b1 || out_wb_data !== 32'h10 || out_reg_write !== 1'b1 || out_rd !== 5'd3) begin
      miscompares++;
      $display("FAIL basic: valid=%b wb=%h rw=%b rd=%0d, want 1/00000010/1/3",
               out_valid, out_wb_data, out_reg_write, out_rd);
    end
    tick();
    vectors++;
    if (out_valid !== 1'b0 || out_reg_write !== 1'b0) begin
      miscompares++;
      $display("FAIL basic_drain: valid=%b rw=%b, want 0/0", out_valid, out_reg_write);
    end
  endtask

  task automatic test_skid();
    out_ready = 1'b0;
    drive(1'b1, 32'h0000_00A0, 32'h0, 5'd4, 1'b0, 1'b1);
    tick();
    vectors++;
    if (out_rd !== 5'd4 || in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL skid_a: rd=%0d in_ready=%b, want 4/1", out_rd, in_ready);
    end
    drive(1'b1, 32'h0000_00B0, 32'h0, 5'd5, 1'b0, 1'b1);
    tick();
    drive(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0);
    vectors++;
    if (in_ready !== 1'b0 || out_rd !== 5'd4 || out_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL skid_full: in_ready=%b rd=%0d valid=%b, want 0/4/1", in_ready, out_rd, out_valid);
    end
    tick();
    vectors++;
    if (out_rd !== 5'd4 || out_wb_data !== 32'hA0 || in_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL skid_stall: rd=%0d wb=%h in_ready=%b, want 4/000000a0/0", out_rd, out_wb_data, in_ready);
    end
    out_ready = 1'b1;
    tick();
    vectors++;
    if (out_valid !== 1'b1 || out_rd !== 5'd5 || out_wb_data !== 32'hB0 || in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL skid_b: valid=%b rd=%0d wb=%h in_ready=%b, want 1/5/000000b0/1",
               out_valid, out_rd, out_wb_data, in_ready);
    end
    tick();
    vectors++;
    if (out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL skid_drain: valid=%b, want 0", out_valid);
    end
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'h100 + 32'(i), 32'h0, 5'(11 + i), 1'b0, 1'b1);
      tick();
      vectors++;
      if (out_valid !== 1'b1 || out_rd !== 5'(11 + i) || out_wb_data !== 32'h100 + 32'(i) || in_ready !== 1'b1) begin
        miscompares++;
        $display("FAIL b2b_%0d: valid=%b rd=%0d wb=%h in_ready=%b, want 1/%0d/%h/1",
                 i, out_valid, out_rd, out_wb_data, in_ready, 11 + i, 32'h100 + 32'(i));
      end
    end
    drive(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0);
    tick();
  endtask

  task automatic test_rd_zero();
    out_ready = 1'b0;
    drive(1'b1, 32'h0000_0044, 32'hDEAD_BEEF, 5'd0, 1'b1, 1'b1);
    tick();
    drive(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0);
    vectors++;
    if (out_valid !== 1'b1 || out_wb_data !== 32'hDEAD_BEEF || out_reg_write !== 1'b0 || out_alu_result !== 32'h44) begin
      miscompares++;
      $display("FAIL rd_zero: valid=%b wb=%h rw=%b alu=%h, want 1/deadbeef/0/00000044",
               out_valid, out_wb_data, out_reg_write, out_alu_result);
    end
    out_ready = 1'b1;
    tick();
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    drive(1'b1, 32'h0000_00C0, 32'h0, 5'd8, 1'b0, 1'b1);
    tick();
    drive(1'b1, 32'h0000_00D0, 32'h0, 5'd9, 1'b0, 1'b1);
    tick();
    flush = 1'b1;
    drive(1'b1, 32'h0000_00E0, 32'h0, 5'd10, 1'b0, 1'b1);
    tick();
    flush = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0);
    vectors++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_reg_write !== 1'b0 || out_rd !== 5'd8) begin
      miscompares++;
      $display("FAIL flush: valid=%b in_ready=%b rw=%b rd=%0d, want 0/1/0/8",
               out_valid, in_ready, out_reg_write, out_rd);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      vectors++;
      if (out_valid !== 1'b0) begin
        miscompares++;
        $display("FAIL flush_ghost_%0d: valid=%b rd=%0d, want valid 0", i, out_valid, out_rd);
      end
    end
  endtask

`ifdef WB_FWD_EN
  task automatic test_fwd();
    out_ready = 1'b0;
    drive(1'b1, 32'h0000_0055, 32'h0, 5'd7, 1'b0, 1'b1);
    tick();
    drive(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0);
    fwd_rs = {5'd0, 5'd7};
    #1;
    vectors++;
    if (fwd_hit !== 2'b01 || fwd_data !== 64'h0000_0000_0000_0055) begin
      miscompares++;
      $display("FAIL fwd_hit: hit=%b data=%h, want 01/0000000000000055", fwd_hit, fwd_data);
    end
    fwd_rs = 10'd0;
    #1;
    vectors++;
    if (fwd_hit !== 2'b00 || fwd_data !== 64'd0) begin
      miscompares++;
      $display("FAIL fwd_zero: hit=%b data=%h, want 00/0", fwd_hit, fwd_data);
    end
    out_ready = 1'b1;
    tick();
  endtask
`endif

  initial begin
`ifdef WB_FWD_EN
    fwd_rs = 10'd0;
`endif
    test_reset();
    test_basic();
    test_skid();
    test_back_to_back();
    test_rd_zero();
    test_flush();
`ifdef WB_FWD_EN
    test_fwd();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
